// File: rtl/branch_resolve_unit.sv
// Branch resolution for the execute stage: RV32I compare, target generation,
// bimodal 2-bit BHT for fetch prediction, and branch/mispredict event counters.
module branch_resolve_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  fetch_pc,
    output logic             fetch_pred_taken,
    input  logic             rs_valid,
    input  logic             rs_flush,
    input  logic [2:0]       rs_func3,
    input  logic [XLEN-1:0]  rs_op_a,
    input  logic [XLEN-1:0]  rs_op_b,
    input  logic [XLEN-1:0]  rs_pc,
    input  logic [XLEN-1:0]  rs_imm,
    input  logic             rs_pred_taken,
    output logic             res_valid,
    output logic             res_taken,
    output logic             res_illegal,
    output logic             res_mispredict,
    output logic [XLEN-1:0]  res_redirect_pc,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mp_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       bht_q [BHT_ENTRIES];
    logic [1:0]       bht_d [BHT_ENTRIES];
    logic             res_valid_q, res_valid_d;
    logic             res_taken_q, res_taken_d;
    logic             res_illegal_q, res_illegal_d;
    logic             res_mispredict_q, res_mispredict_d;
    logic [XLEN-1:0]  res_redirect_pc_q, res_redirect_pc_d;
    logic [CNT_W-1:0] br_count_q, br_count_d;
    logic [CNT_W-1:0] mp_count_q, mp_count_d;

    logic [XLEN:0]    diff;
    logic             eq, lt, ltu;
    logic             taken_c, illegal_c;
    logic             acc, legal;
    logic [XLEN-1:0]  pc_seq, pc_tgt;
    logic [IDX_W-1:0] fetch_idx, rs_idx;
    logic [1:0]       ctr_cur;
    logic             unused_fetch_bits;

    assign fetch_idx = fetch_pc[IDX_W+1:2];
    assign rs_idx    = rs_pc[IDX_W+1:2];
    assign unused_fetch_bits = ^{fetch_pc[XLEN-1:IDX_W+2], fetch_pc[1:0]};

    // Lookup deliberately ignores any same-cycle update: fetch sees pre-edge state.
    assign fetch_pred_taken = bht_q[fetch_idx][1];

    always_comb begin
        diff = {1'b0, rs_op_a} - {1'b0, rs_op_b};
        eq   = (diff[XLEN-1:0] == '0);
        ltu  = diff[XLEN];
        lt   = (rs_op_a[XLEN-1] != rs_op_b[XLEN-1]) ? rs_op_a[XLEN-1] : diff[XLEN-1];

        taken_c   = 1'b0;
        illegal_c = 1'b0;
        case (rs_func3)
            3'b000:  taken_c = eq;
            3'b001:  taken_c = ~eq;
            3'b100:  taken_c = lt;
            3'b101:  taken_c = ~lt;
            3'b110:  taken_c = ltu;
            3'b111:  taken_c = ~ltu;
            default: illegal_c = 1'b1;
        endcase

        pc_seq = rs_pc + XLEN'(4);
        pc_tgt = rs_pc + rs_imm;
    end

    always_comb begin
        acc   = rs_valid & ~rs_flush;
        legal = acc & ~illegal_c;

        res_valid_d       = acc;
        res_taken_d       = res_taken_q;
        res_illegal_d     = res_illegal_q;
        res_mispredict_d  = res_mispredict_q;
        res_redirect_pc_d = res_redirect_pc_q;
        br_count_d        = br_count_q;
        mp_count_d        = mp_count_q;
        bht_d             = bht_q;
        ctr_cur           = bht_q[rs_idx];

        if (acc) begin
            res_taken_d       = taken_c;
            res_illegal_d     = illegal_c;
            res_mispredict_d  = legal & (taken_c != rs_pred_taken);
            res_redirect_pc_d = taken_c ? pc_tgt : pc_seq;
        end

        if (legal) begin
            br_count_d = br_count_q + CNT_W'(1);
            if (taken_c != rs_pred_taken) begin
                mp_count_d = mp_count_q + CNT_W'(1);
            end
            if (taken_c && ctr_cur != 2'b11) begin
                bht_d[rs_idx] = ctr_cur + 2'b01;
            end else if (!taken_c && ctr_cur != 2'b00) begin
                bht_d[rs_idx] = ctr_cur - 2'b01;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= 2'b01;
            end
            res_valid_q       <= 1'b0;
            res_taken_q       <= 1'b0;
            res_illegal_q     <= 1'b0;
            res_mispredict_q  <= 1'b0;
            res_redirect_pc_q <= '0;
            br_count_q        <= '0;
            mp_count_q        <= '0;
        end else begin
            bht_q             <= bht_d;
            res_valid_q       <= res_valid_d;
            res_taken_q       <= res_taken_d;
            res_illegal_q     <= res_illegal_d;
            res_mispredict_q  <= res_mispredict_d;
            res_redirect_pc_q <= res_redirect_pc_d;
            br_count_q        <= br_count_d;
            mp_count_q        <= mp_count_d;
        end
    end

    assign res_valid       = res_valid_q;
    assign res_taken       = res_taken_q;
    assign res_illegal     = res_illegal_q;
    assign res_mispredict  = res_mispredict_q;
    assign res_redirect_pc = res_redirect_pc_q;
    assign br_count        = br_count_q;
    assign mp_count        = mp_count_q;

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch resolution unit for the RISC-V core's execute stage. It evaluates all six RV32I conditional-branch comparisons, computes the branch target, and registers the result one cycle later. It also owns a bimodal branch history table (BHT) of 2-bit saturating counters, which fetch reads for direction prediction and which updates on every resolved branch. It reports mispredictions with the corrective redirect PC and keeps branch and mispredict event counters.

## Interface
- XLEN, 32, operand/PC width (≥32)
- BHT_ENTRIES, 64, BHT depth; power of two, ≥4; IDX_W = log2(BHT_ENTRIES)
- CNT_W, 32, width of event counters
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- fetch_pc  in  XLEN  PC being fetched
- fetch_pred_taken  out  1  combinational prediction for fetch_pc
- rs_valid  in  1  resolve request valid
- rs_flush  in  1  kill request presented this cycle
- rs_func3  in  3  branch func3
- rs_op_a, rs_op_b  in  XLEN  rs1/rs2 values
- rs_pc  in  XLEN  branch PC
- rs_imm  in  XLEN  sign-extended B-immediate
- rs_pred_taken  in  1  prediction fetch made for this branch
- res_valid  out  1  registered result valid (one-cycle pulse per request)
- res_taken  out  1  actual direction
- res_illegal  out  1  func3 ∈ {010, 011}
- res_mispredict  out  1  direction mismatch
- res_redirect_pc  out  XLEN  correct next PC
- br_count  out  CNT_W  resolved legal branches
- mp_count  out  CNT_W  mispredictions

## Operation
- Index: idx(pc) = pc[IDX_W+1:2].
- Prediction: fetch_pred_taken = BHT[idx(fetch_pc)][1]. Purely combinational; no bypass of a same-cycle update (returns pre-update value).
- Accept: acc = rs_valid & ~rs_flush. Non-accepted cycles change no state except clearing res_valid.
- Compare on full XLEN: d = {1'b0,op_a} − {1'b0,op_b} (XLEN+1 bits). eq = (d[XLEN-1:0]==0). ltu = d[XLEN] (borrow). lt = signed less-than: op_a[XLEN-1]≠op_b[XLEN-1] ? op_a[XLEN-1] : d[XLEN-1].
- func3: 000 eq, 001 ~eq, 100 lt, 101 ~lt, 110 ltu, 111 ~ltu. 010/011: taken=0, illegal=1.
- Target: taken ? rs_pc + rs_imm : rs_pc + 4, modulo 2^XLEN (wrap, no fault).
- Legal accepted branch: mispredict = taken ≠ rs_pred_taken. Illegal: mispredict=0, redirect_pc = rs_pc+4, no BHT or counter update.
- BHT update (legal only) at idx(rs_pc): taken → saturating increment (max 11); not-taken → saturating decrement (min 00). States: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Counters: br_count += 1 per legal accept; mp_count += 1 when that accept also mispredicts. Both wrap modulo 2^CNT_W.
- Reset: all BHT entries := 01; res_valid, res_taken, res_illegal, res_mispredict := 0; res_redirect_pc := 0; br_count, mp_count := 0. Reset overrides a simultaneous rs_valid; that request is dropped.

## Timing
- Latency 1: request accepted at edge N → res_* valid during cycle N+1 only. Throughput one request per cycle, no stall port.
- res_taken/illegal/mispredict/redirect_pc hold their last values when res_valid=0; consumers qualify with res_valid.
- BHT and counters update on the same edge that registers the result; a fetch lookup of that index in cycle N+1 sees the new value.
- Back-to-back resolves on the same index apply sequentially, one step each.
- rs_flush in the same cycle as rs_valid suppresses the request entirely. A result already registered is not retracted; flushing it is downstream's job.
- Reset taking effect mid-stream: the next cycle has res_valid=0 and the BHT is freshly 01.

## Test plan
- Reset then fetch_pc=0x100 → fetch_pred_taken=0; br_count=mp_count=0; res_valid=0.
- blt op_a=0xFFFFFFFF, op_b=1, pred=0 → next cycle res_taken=1, mispredict=1, redirect=pc+imm; bltu on the same operands → taken=0, redirect=pc+4.
- Three taken beq on pc=0x40 (op_a=op_b=5) → BHT[16] goes 01→10→11→11; fetch_pred_taken at 0x40 becomes 1 after the first; br_count=3.
- func3=010 accepted → res_illegal=1, res_taken=0, br_count unchanged, BHT[idx] unchanged.
- rs_valid=1 with rs_flush=1 → res_valid=0 next cycle, no counter change; rst asserted alongside rs_valid → request dropped.
- rs_pc=0xFFFFFFFC, imm=8, taken bne → redirect=0x00000004; not-taken → redirect=0x00000000.
